// File: rtl/if_id_stage_if.sv
// -----------------------------------------------------------------------------
// if_id_stage_if
// Bundle between the fetch side (PC unit + instruction memory) and the IF/ID
// pipeline register. The master side drives the fetch address, the memory
// read data and the pipeline controls; the slave side (the IF/ID register)
// returns the decode bundle and the stall-hang flag.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface if_id_stage_if #(
  parameter int DATA_W = 32
) ();

  // Fetch side
  logic [DATA_W-1:0] pc_if;
  logic [DATA_W-1:0] imem_rdata;
  logic              is_branch;
  logic              load_stop;

  // Decode side
  logic              id_valid;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] id_pc4;
  logic [DATA_W-1:0] id_inst;
  logic              stall_timeout;

  modport master (
    output pc_if,
    output imem_rdata,
    output is_branch,
    output load_stop,
    input  id_valid,
    input  id_pc,
    input  id_pc4,
    input  id_inst,
    input  stall_timeout
  );

  modport slave (
    input  pc_if,
    input  imem_rdata,
    input  is_branch,
    input  load_stop,
    output id_valid,
    output id_pc,
    output id_pc4,
    output id_inst,
    output stall_timeout
  );

endinterface : if_id_stage_if

// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
// IF/ID pipeline register sitting behind the PC unit and a synchronous
// instruction memory. A fetch tag (f_pc/f_vld) remembers which address the
// memory is currently returning data for; the ID register then pairs that tag
// with imem_rdata and presents {valid, pc, pc+4, inst} to decode.
//
// Controls (same signals the PC unit obeys):
//   is_branch : flush - ID loads a bubble and the in-flight fetch is killed.
//   load_stop : stall - ID holds; the PC unit re-drives the same address.
//   Priority is is_branch > load_stop > advance.
//
// A saturating counter measures consecutive stall cycles; stall_timeout is a
// sticky flag raised once load_stop has been held for more than MAX_STALL
// consecutive cycles (MAX_STALL must be in 1..255). Cleared only by reset.
//
// Optional build macro IF_ID_PERF_CNT_EN adds two free-running 32-bit
// performance counters: perf_bubble_cnt (edges where ID loads a bubble) and
// perf_stall_cnt (edges where ID holds). Without the macro neither the ports
// nor the counters exist.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module if_id_stage #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INST  = DATA_W'(32'h0000_0013),
  parameter int                MAX_STALL = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  if_id_stage_if.slave bus
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  // WARM  : first edge after reset release; memory output not yet meaningful.
  // RUN   : normal flow.
  // STALL : load_stop has been seen; ID is frozen until it drops.
  typedef enum logic [1:0] {
    ST_WARM  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] PC_STEP     = DATA_W'(4);
  localparam logic [7:0]        STALL_LIMIT = 8'(MAX_STALL);
  localparam logic [7:0]        STALL_SAT   = 8'hFF;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t            r_state;
  logic [DATA_W-1:0] r_f_pc;          // address the memory is returning data for
  logic              r_f_vld;         // that fetch is on the correct path
  logic [7:0]        r_stall_cnt;     // consecutive stall cycles, saturating
  logic              r_stall_timeout;

  logic              r_id_valid;
  logic [DATA_W-1:0] r_id_pc;
  logic [DATA_W-1:0] r_id_pc4;
  logic [DATA_W-1:0] r_id_inst;

  // ---------------------------------------------------------------------------
  // Combinational decisions
  // ---------------------------------------------------------------------------
  state_t            w_state_nxt;
  logic              w_load_bubble;   // ID takes a bubble this edge
  logic              w_hold;          // ID keeps its contents this edge
  logic              w_advance;       // ID takes the tagged fetch this edge
  logic              w_f_vld_nxt;
  logic [7:0]        w_stall_cnt_nxt;
  logic              w_timeout_set;
  logic [DATA_W-1:0] w_f_pc4;

  logic              w_id_valid_nxt;
  logic [DATA_W-1:0] w_id_pc_nxt;
  logic [DATA_W-1:0] w_id_pc4_nxt;
  logic [DATA_W-1:0] w_id_inst_nxt;

  // Wraps modulo 2^DATA_W, so 0xFFFFFFFC + 4 yields 0.
  assign w_f_pc4 = r_f_pc + PC_STEP;

  // Next-state and per-edge action selection.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_load_bubble   = 1'b0;
    w_hold          = 1'b0;
    w_advance       = 1'b0;
    w_f_vld_nxt     = 1'b1;
    w_stall_cnt_nxt = '0;
    w_timeout_set   = 1'b0;

    case (r_state)
      ST_WARM: begin
        // Memory data is meaningless on this edge; controls are ignored.
        w_load_bubble = 1'b1;
        w_f_vld_nxt   = 1'b1;
        w_state_nxt   = ST_RUN;
      end

      ST_RUN: begin
        if (bus.is_branch) begin
          // Flush wins even over a simultaneous stall.
          w_load_bubble = 1'b1;
          w_f_vld_nxt   = 1'b0;
        end else if (bus.load_stop) begin
          w_hold          = 1'b1;
          w_f_vld_nxt     = r_f_vld;
          w_stall_cnt_nxt = 8'd1;
          w_state_nxt     = ST_STALL;
        end else begin
          w_advance = 1'b1;
        end
      end

      ST_STALL: begin
        if (bus.is_branch) begin
          w_load_bubble = 1'b1;
          w_f_vld_nxt   = 1'b0;
          w_state_nxt   = ST_RUN;
        end else if (bus.load_stop) begin
          w_hold          = 1'b1;
          w_f_vld_nxt     = r_f_vld;
          w_stall_cnt_nxt = (r_stall_cnt == STALL_SAT) ? STALL_SAT
                                                       : r_stall_cnt + 8'd1;
          // Already MAX_STALL cycles counted and the stall persists.
          w_timeout_set   = (r_stall_cnt >= STALL_LIMIT);
        end else begin
          w_advance   = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end

      default: begin
        // Unreachable encoding: recover through a bubble into WARM.
        w_load_bubble = 1'b1;
        w_state_nxt   = ST_WARM;
      end
    endcase
  end

  // Data selected for the ID register on this edge.
  always_comb begin
    w_id_valid_nxt = r_id_valid;
    w_id_pc_nxt    = r_id_pc;
    w_id_pc4_nxt   = r_id_pc4;
    w_id_inst_nxt  = r_id_inst;

    if (w_load_bubble) begin
      // pc fields still follow the tag so a bubble shows where it came from.
      w_id_valid_nxt = 1'b0;
      w_id_pc_nxt    = r_f_pc;
      w_id_pc4_nxt   = w_f_pc4;
      w_id_inst_nxt  = NOP_INST;
    end else if (w_advance) begin
      w_id_valid_nxt = r_f_vld;
      w_id_pc_nxt    = r_f_pc;
      w_id_pc4_nxt   = w_f_pc4;
      w_id_inst_nxt  = r_f_vld ? bus.imem_rdata : NOP_INST;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------

  // FSM state register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WARM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch tag: follows the issued address every edge; validity per action.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_pc  <= '0;
      r_f_vld <= 1'b0;
    end else begin
      r_f_pc  <= bus.pc_if;
      r_f_vld <= w_f_vld_nxt;
    end
  end

  // Decode bundle register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_valid <= 1'b0;
      r_id_pc    <= '0;
      r_id_pc4   <= PC_STEP;
      r_id_inst  <= NOP_INST;
    end else begin
      r_id_valid <= w_id_valid_nxt;
      r_id_pc    <= w_id_pc_nxt;
      r_id_pc4   <= w_id_pc4_nxt;
      r_id_inst  <= w_id_inst_nxt;
    end
  end

  // Stall-length counter and sticky hang flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt     <= '0;
      r_stall_timeout <= 1'b0;
    end else begin
      r_stall_cnt <= w_stall_cnt_nxt;
      if (w_timeout_set) begin
        r_stall_timeout <= 1'b1;
      end
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] r_perf_bubble_cnt;
  logic [31:0] r_perf_stall_cnt;
  logic        w_bubble_evt;

  // A bubble is either an explicit one or an advance of a killed fetch.
  assign w_bubble_evt = w_load_bubble | (w_advance & ~r_f_vld);

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_bubble_cnt <= '0;
      r_perf_stall_cnt  <= '0;
    end else begin
      if (w_bubble_evt) begin
        r_perf_bubble_cnt <= r_perf_bubble_cnt + 32'd1;
      end
      if (w_hold) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
    end
  end

  assign perf_bubble_cnt = r_perf_bubble_cnt;
  assign perf_stall_cnt  = r_perf_stall_cnt;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.id_valid      = r_id_valid;
  assign bus.id_pc         = r_id_pc;
  assign bus.id_pc4        = r_id_pc4;
  assign bus.id_inst       = r_id_inst;
  assign bus.stall_timeout = r_stall_timeout;

endmodule : if_id_stage

// File: tb/tb_if_id_stage.sv
// -----------------------------------------------------------------------------
// tb_if_id_stage
// Bench for if_id_stage. The bench plays the PC unit and a synchronous
// instruction memory (data is a fixed function of the address, returned one
// edge after the address is sampled). Expected decode bundles come from a
// transaction-level reference model and are queued per clock edge; an
// independent monitor pops and compares one bundle after every edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_if_id_stage;

  localparam int          DATA_W    = 32;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam int          MAX_STALL = 15;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        to;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  if_id_stage_if #(.DATA_W(DATA_W)) bus ();

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] perf_bubble_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  if_id_stage #(
    .DATA_W   (DATA_W),
    .NOP_INST (NOP),
    .MAX_STALL(MAX_STALL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .perf_bubble_cnt(perf_bubble_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // ---------------------------------------------------------------------------
  // Instruction memory model: contents are a fixed function of the address.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0010_0093;
      32'h0000_0004: return 32'h0020_0113;
      32'h0000_0008: return 32'h0030_8193;
      default:       return ((a ^ 32'h5A5A_0000) * 32'h9E37_79B1) + 32'h0000_0033;
    endcase
  endfunction

  logic [31:0] mem_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_addr <= 32'hDEAD_BEE0;
    else        mem_addr <= bus.pc_if;
  end

  assign bus.imem_rdata = mem_word(mem_addr);

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: what the decode stage should hold after each edge.
  //   m_warm  : the next edge is the first after reset
  //   m_fpc   : address whose data the memory is presenting
  //   m_flive : that fetch is on the correct path
  //   m_run   : length of the current run of consecutive stall cycles
  //   p_next  : next sequential address the PC unit would issue
  // ---------------------------------------------------------------------------
  bit          m_warm;
  logic [31:0] m_fpc;
  bit          m_flive;
  int          m_run;
  exp_t        m_id;
  logic [31:0] p_next;

  task automatic model_reset();
    m_warm  = 1'b1;
    m_fpc   = 32'h0;
    m_flive = 1'b0;
    m_run   = 0;
    m_id    = '{valid: 1'b0, pc: 32'h0, pc4: 32'h4, inst: NOP, to: 1'b0};
    p_next  = 32'h0;
    exp_q.delete();
  endtask

  task automatic make_bubble();
    m_id.valid = 1'b0;
    m_id.pc    = m_fpc;
    m_id.pc4   = m_fpc + 32'd4;
    m_id.inst  = NOP;
  endtask

  // One clock cycle: drive inputs, predict the post-edge bundle, wait the edge.
  task automatic step(input logic [31:0] pc, input bit br, input bit ls);
    bus.pc_if     = pc;
    bus.is_branch = br;
    bus.load_stop = ls;
    if (m_warm) begin
      make_bubble();
      m_flive = 1'b1;
      m_warm  = 1'b0;
      m_run   = 0;
    end else if (br) begin
      make_bubble();
      m_flive = 1'b0;
      m_run   = 0;
    end else if (ls) begin
      m_run++;
      if (m_run > MAX_STALL) m_id.to = 1'b1;
    end else begin
      m_id.valid = m_flive;
      m_id.pc    = m_fpc;
      m_id.pc4   = m_fpc + 32'd4;
      m_id.inst  = m_flive ? mem_word(m_fpc) : NOP;
      m_flive    = 1'b1;
      m_run      = 0;
    end
    m_fpc = pc;
    exp_q.push_back(m_id);
    @(posedge clk);
    #2;
  endtask

  // PC-unit behaviours built on step().
  task automatic seq(input int n);
    repeat (n) begin
      step(p_next, 1'b0, 1'b0);
      p_next = p_next + 32'd4;
    end
  endtask

  // While stalled the PC unit re-drives the address being fetched.
  task automatic stall(input int n);
    repeat (n) step(m_fpc, 1'b0, 1'b1);
  endtask

  task automatic branch(input logic [31:0] target, input bit ls);
    step(p_next, 1'b1, ls);
    p_next = target;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " id_valid"},      32'(bus.id_valid),      32'd0);
    check({tag, " id_pc"},         bus.id_pc,              32'h0);
    check({tag, " id_pc4"},        bus.id_pc4,             32'h4);
    check({tag, " id_inst"},       bus.id_inst,            NOP);
    check({tag, " stall_timeout"}, 32'(bus.stall_timeout), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: after every edge out of reset, compare against the queued bundle.
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("mon id_valid",      32'(bus.id_valid),      32'(mon_e.valid));
      check("mon id_pc",         bus.id_pc,              mon_e.pc);
      check("mon id_pc4",        bus.id_pc4,             mon_e.pc4);
      check("mon id_inst",       bus.id_inst,            mon_e.inst);
      check("mon stall_timeout", 32'(bus.stall_timeout), 32'(mon_e.to));
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bus.pc_if     = 32'h0;
    bus.is_branch = 1'b0;
    bus.load_stop = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #2;
    check_reset_values("reset");
    rst_n = 1'b1;

    // Sequential fetch 0,4,8,C: WARM bubble, then 0, 4, 8 in order.
    seq(4);
    check("seq id_valid", 32'(bus.id_valid), 32'd1);
    check("seq id_pc",    bus.id_pc,         32'h8);
    check("seq id_inst",  bus.id_inst,       32'h0030_8193);

    // Three-cycle load stall holding 0x8; release yields 0xC.
    stall(3);
    check("stall hold id_pc", bus.id_pc, 32'h8);
    seq(1);
    check("stall release id_pc", bus.id_pc, 32'hC);

    // Branch flush to 0x40: bubble, killed fetch, then 0x40.
    branch(32'h40, 1'b0);
    check("flush id_valid", 32'(bus.id_valid), 32'd0);
    check("flush id_inst",  bus.id_inst,       NOP);
    seq(1);
    check("killed fetch id_valid", 32'(bus.id_valid), 32'd0);
    seq(1);
    check("target id_pc",    bus.id_pc,         32'h40);
    check("target id_valid", 32'(bus.id_valid), 32'd1);

    // Simultaneous flush and stall in RUN: bubble, not hold.
    branch(32'h80, 1'b1);
    check("flush+stall id_valid", 32'(bus.id_valid), 32'd0);
    seq(3);

    // Flush while in STALL returns to normal flow.
    stall(2);
    branch(32'h100, 1'b0);
    seq(3);

    // Stall timeout: 15 cycles tolerated, the 16th raises the sticky flag.
    stall(15);
    check("timeout after 15", 32'(bus.stall_timeout), 32'd0);
    stall(1);
    check("timeout after 16", 32'(bus.stall_timeout), 32'd1);
    seq(4);
    check("timeout sticky", 32'(bus.stall_timeout), 32'd1);

    // pc+4 wraps at the top of the address space.
    branch(32'hFFFF_FFF8, 1'b0);
    seq(3);
    check("wrap id_pc",  bus.id_pc,  32'hFFFF_FFFC);
    check("wrap id_pc4", bus.id_pc4, 32'h0);

    // Asynchronous reset asserted between edges while stalled.
    stall(3);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("async reset");
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    seq(5);

    // Randomised flow: flushes, stalls and both together.
    for (int i = 0; i < 400; i++) begin
      bit br;
      bit ls;
      br = ($urandom_range(0, 7) == 0);
      ls = ($urandom_range(0, 3) == 0);
      if (br) begin
        branch({$urandom()} & 32'hFFFF_FFFC, ls);
      end else if (ls) begin
        stall(1);
      end else begin
        seq(1);
      end
    end
    seq(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_if_id_stage
